// File: rtl/ibex_dmem_pkg.sv
// Shared types for the data-memory responder: response entry, grant FSM states
// and the grant-wait counter width.
package ibex_dmem_pkg;

  localparam int GntCntW = 3;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_entry_t;

  typedef enum logic [1:0] {
    GS_IDLE,
    GS_WAIT,
    GS_GRANT
  } gnt_state_e;

endpackage

// File: rtl/ibex_dmem_resp_pipe.sv
// Fixed-latency response shift register. An entry captured at the accept edge
// appears on o_entry RespLatency cycles later; async clear drops anything in flight.
module ibex_dmem_resp_pipe
  import ibex_dmem_pkg::*;
#(
  parameter int RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  resp_entry_t i_entry,
  output resp_entry_t o_entry
);

  resp_entry_t r_stage [RespLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RespLatency; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < RespLatency; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_entry = r_stage[RespLatency-1];

endmodule

// File: rtl/ibex_dmem_responder.sv
// Word-organised data RAM on the req/gnt/rvalid bus: optional grant delay,
// byte-enabled writes, range-checked decode and in-order fixed-latency responses.
module ibex_dmem_responder
  import ibex_dmem_pkg::*;
#(
  parameter int          MemWords    = 1024,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          GntWait     = 0,
  parameter int          RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int                  IdxW     = $clog2(MemWords);
  localparam logic [GntCntW-1:0]  GntWaitC = GntWait[GntCntW-1:0];

  logic [31:0]        r_mem [MemWords];
  gnt_state_e         r_state, w_state_nxt;
  logic [GntCntW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               w_gnt, w_accept, w_in_range;
  logic [31:0]        w_off, w_word;
  logic [IdxW-1:0]    w_idx;
  resp_entry_t        w_entry, w_resp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= GS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + GntCntW'(1);

  // The grant lands on req cycle GntWait+1; a dropped req abandons the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    if (GntWait == 0) begin
      w_gnt = data_req_i;
    end else begin
      unique case (r_state)
        GS_IDLE: begin
          if (data_req_i) begin
            w_cnt_nxt   = GntCntW'(1);
            w_state_nxt = (GntWaitC == GntCntW'(1)) ? GS_GRANT : GS_WAIT;
          end
        end
        GS_WAIT: begin
          if (data_req_i) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == GntWaitC) w_state_nxt = GS_GRANT;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = GS_IDLE;
          end
        end
        GS_GRANT: begin
          w_gnt       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = GS_IDLE;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = GS_IDLE;
        end
      endcase
    end
  end

  assign data_gnt_o = w_gnt;
  assign w_accept   = data_req_i & w_gnt;

  // Addresses below BaseAddr wrap to huge offsets and fall out of range.
  assign w_off      = data_addr_i - BaseAddr;
  assign w_word     = w_off >> 2;
  assign w_in_range = w_word < 32'(MemWords);
  assign w_idx      = w_word[IdxW-1:0];

  always_ff @(posedge clk_i) begin
    if (w_accept && data_we_i && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_entry       = '0;
    w_entry.valid = w_accept;
    w_entry.err   = w_accept & ~w_in_range;
    if (w_accept && !data_we_i && w_in_range) w_entry.rdata = r_mem[w_idx];
  end

  ibex_dmem_resp_pipe #(
    .RespLatency(RespLatency)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_entry(w_entry),
    .o_entry(w_resp)
  );

  assign data_rvalid_o = w_resp.valid;
  assign data_err_o    = w_resp.err;
  assign data_rdata_o  = w_resp.rdata;

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// Scoreboard bench: four responder configurations share one stimulus bus; a
// negedge monitor matches every rvalid against the queued expectation and cycle.
module tb_ibex_dmem_responder;

  typedef struct {
    int          inst;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  localparam int RL [4] = '{1, 2, 1, 3};
  localparam int GW [4] = '{0, 0, 3, 0};

  logic        clk, rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  int          sel;
  logic [3:0]  req_v, gnt, rvalid, err;
  logic [31:0] rdata [4];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q [$];
  exp_t m_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_req
    assign req_v[g] = req && (sel == g);
  end

  ibex_dmem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntWait(0), .RespLatency(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_v[0]), .data_gnt_o(gnt[0]),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  ibex_dmem_responder #(.MemWords(64), .BaseAddr(32'h0), .GntWait(0), .RespLatency(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_v[1]), .data_gnt_o(gnt[1]),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  ibex_dmem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntWait(3), .RespLatency(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_v[2]), .data_gnt_o(gnt[2]),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  ibex_dmem_responder #(.MemWords(16), .BaseAddr(32'h1000), .GntWait(0), .RespLatency(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_v[3]), .data_gnt_o(gnt[3]),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]), .data_err_o(err[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rvalid[i]) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected inst=%0d cyc=%0d: got rdata=%h err=%0b, want no response",
                   i, cyc, rdata[i], err[i]);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.inst != i || m_e.cyc != cyc || m_e.err !== err[i] || m_e.rdata !== rdata[i]) begin
            errors++;
            $display("FAIL resp inst=%0d cyc=%0d: got err=%0b rdata=%h, want inst=%0d cyc=%0d err=%0b rdata=%h",
                     i, cyc, err[i], rdata[i], m_e.inst, m_e.cyc, m_e.err, m_e.rdata);
          end
        end
      end else if (rdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL rdata_idle inst=%0d cyc=%0d: got %h, want 0", i, cyc, rdata[i]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int inst, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rdata);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    sel = inst; we = w; addr = a; be = b; wdata = wd; req = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (gnt[inst]) begin
        got = 1'b1;
        exp_q.push_back('{inst, cyc + RL[inst], e_err, e_rdata});
      end
    end
    checks++;
    if (!got || n != GW[inst] + 1) begin
      errors++;
      $display("FAIL gnt_wait inst=%0d addr=%h: got grant after %0d cycles (granted=%0b), want %0d",
               inst, a, n, got, GW[inst] + 1);
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_gnt", {28'h0, gnt}, 32'h0);
    chk("reset_rvalid", {28'h0, rvalid}, 32'h0);
    chk("reset_err", {28'h0, err}, 32'h0);
    @(posedge clk);
    #1;

    // Basic write/read, same-cycle grant, one-cycle latency
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
    // Byte lanes and the empty byte-enable write
    issue(0, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h20, 4'h5, 32'h11223344, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'hFF22FF44);
    issue(0, 1'b1, 32'h20, 4'h0, 32'hAABBCCDD, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'hFF22FF44);
    drain();

    // Back-to-back split-access pattern with two-cycle latency: grants overlap rvalids
    issue(1, 1'b1, 32'h40, 4'hF, 32'h01020304, 1'b0, 32'h0);
    issue(1, 1'b1, 32'h44, 4'hF, 32'h05060708, 1'b0, 32'h0);
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0,        1'b0, 32'h01020304);
    issue(1, 1'b0, 32'h44, 4'hF, 32'h0,        1'b0, 32'h05060708);
    drain();

    // Delayed grant: abandoned request gets nothing, held request waits 4 cycles
    sel = 2; we = 1'b0; addr = 32'h8; be = 4'hF; req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("gnt_abandoned", {31'h0, gnt[2]}, 32'h0);
    end
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(2, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(2, 1'b0, 32'h8, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D);
    drain();

    // Range checks on a small RAM at a non-zero base
    issue(3, 1'b1, 32'h1000,     4'hF, 32'hA5A5A5A5, 1'b0, 32'h0);
    issue(3, 1'b1, 32'h103C,     4'hF, 32'h5A5A5A5A, 1'b0, 32'h0);
    issue(3, 1'b0, 32'h1040,     4'hF, 32'h0,        1'b1, 32'h0);
    issue(3, 1'b1, 32'h0FFC,     4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(3, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        1'b1, 32'h0);
    issue(3, 1'b0, 32'h1000,     4'hF, 32'h0,        1'b0, 32'hA5A5A5A5);
    issue(3, 1'b0, 32'h103C,     4'hF, 32'h0,        1'b0, 32'h5A5A5A5A);
    drain();

    // Reset with two responses in flight
    issue(3, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 32'hA5A5A5A5);
    issue(3, 1'b0, 32'h103C, 4'hF, 32'h0, 1'b0, 32'h5A5A5A5A);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_rvalid", {31'h0, rvalid[3]}, 32'h0);
    chk("rst_rdata", rdata[3], 32'h0);
    chk("rst_err", {31'h0, err[3]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(3, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 32'hA5A5A5A5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
